// File: rtl/uart_sched.sv
// uart_sched: half-duplex sequencer/arbiter in front of the uart core.
// Shares the core transmitter between two byte requesters (round-robin).
// Arms the receiver whenever the line is free. Buffers one received byte
// behind a valid/ready handshake with a sticky overrun flag.
//
// Ports
//   clk, rst (async, active-low)
//   req0/req1, data0/data1, ack0/ack1 : transmit requesters
//   rx_en                             : permit arming the receiver
//   rx_data, rx_valid, rx_ready       : receive buffer handshake
//   rx_overrun, ovr_clr               : sticky drop flag and its clear
//   init_tx, uart_data_in, init_rx    : controls to the core
//   uart_tx_busy, uart_rx_busy, done  : status from the core
//   uart_data_out                     : received byte from the core
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | line free; arm receiver or grant a transmit request
// TX_START | init_tx held; waiting for the core to report tx busy
// TX_WAIT  | core transmitting; wait for tx busy to fall
// RX_BUSY  | core receiving; capture byte on rising edge of done
module uart_sched #(
    parameter int START_TO = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    input  logic       rx_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overrun,
    input  logic       ovr_clr,
    output logic       init_tx,
    output logic [7:0] uart_data_in,
    output logic       init_rx,
    input  logic       uart_tx_busy,
    input  logic       uart_rx_busy,
    input  logic       done,
    input  logic [7:0] uart_data_out
);

    typedef enum logic [1:0] {IDLE, TX_START, TX_WAIT, RX_BUSY} state_t;

    state_t     state;
    logic       last_grant;
    logic       grant;
    logic       done_q;
    logic [3:0] cnt;
    logic       pick;
    logic       rx_pop;
    logic       rx_rise;
    logic       rx_cap;
    logic       rx_drop;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        pick = req1;
        if (req0 && req1) pick = ~last_grant;
    end

    assign rx_pop  = rx_valid & rx_ready;
    assign rx_rise = (state == RX_BUSY) & done & ~done_q;
    // A byte being consumed this cycle frees the buffer for the new one.
    assign rx_cap  = rx_rise & (~rx_valid | rx_ready);
    assign rx_drop = rx_rise & rx_valid & ~rx_ready;

    // State-derived, so init_tx and init_rx can never be high together.
    assign init_tx = rst & (state == TX_START);
    assign init_rx = rst & (state == IDLE) & rx_en & ~req0 & ~req1 & ~uart_tx_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            grant        <= 1'b0;
            cnt          <= '0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
            rx_overrun   <= 1'b0;
            uart_data_in <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= done;
            ack0   <= 1'b0;
            ack1   <= 1'b0;

            if (rx_cap) begin
                rx_data  <= uart_data_out;
                rx_valid <= 1'b1;
            end else if (rx_pop) begin
                rx_valid <= 1'b0;
            end

            if (rx_drop)      rx_overrun <= 1'b1;
            else if (ovr_clr) rx_overrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (uart_rx_busy) begin
                        state <= RX_BUSY;
                    end else if (!uart_tx_busy && (req0 || req1)) begin
                        grant        <= pick;
                        uart_data_in <= pick ? data1 : data0;
                        cnt          <= '0;
                        state        <= TX_START;
                    end
                end
                TX_START: begin
                    // A reception armed in the previous IDLE cycle wins the
                    // line; the request stays pending for a later grant.
                    if (uart_rx_busy) begin
                        state <= RX_BUSY;
                    end else if (uart_tx_busy) begin
                        ack0       <= ~grant;
                        ack1       <= grant;
                        last_grant <= grant;
                        state      <= TX_WAIT;
                    end else if (cnt == 4'(START_TO - 1)) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                TX_WAIT: begin
                    if (!uart_tx_busy) state <= IDLE;
                end
                RX_BUSY: begin
                    if (!uart_rx_busy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
